spart_rx: RTL

Serial receiver for the SPART peripheral, directly downstream of the baud rate generator. It consumes the generator's one-cycle `brg_en` tick (16 ticks per bit time) and oversamples the asynchronous `rxd` line. It deframes 8N1 characters and presents each byte with a sticky data-available flag and error flags for the bus-side register logic.

---
 rtl/spart_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spart_rx.sv
// spart_rx: SPART serial receiver. Oversamples the asynchronous rxd line
// using the baud generator's brg_en tick and deframes 8N1 characters.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   brg_en       baud tick, OVERSAMPLE per bit time
//   rxd          serial input, idles high
//   clr_rda      bus-read strobe; clears rda/framing_err/overrun
//   rx_data      last received byte
//   rda          receive data available (sticky)
//   framing_err  last frame's stop bit sampled low (sticky)
//   overrun      byte loaded while rda was still set (sticky)
//   busy         receiver FSM not idle
module spart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brg_en,
    input  logic                 rxd,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   mid_tick;
    logic                   last_tick;
    logic                   bit_tick;
    logic                   start_ok;
    logic                   load;

    // Synchronizer resets to the idle (high) line level so a reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '1;
        end else begin
            sync[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign rxs       = sync[SYNC_STAGES-1];
    assign mid_tick  = brg_en && (tcnt == T_MID);
    assign last_tick = brg_en && (tcnt == T_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (mid_tick) state_nxt = rxs ? IDLE : DATA;
            DATA:  if (last_tick && (bcnt == B_LAST)) state_nxt = STOP;
            STOP:  if (last_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state != IDLE);
        start_ok = (state == START) && mid_tick && !rxs;
        bit_tick = (state == DATA) && last_tick;
        load     = (state == STOP) && last_tick;
    end

    // Tick counter: parked at 0 in IDLE, re-zeroed at mid start bit so
    // every later sample lands a whole bit period after the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if ((state == START) && mid_tick) begin
            tcnt <= '0;
        end else if (last_tick) begin
            tcnt <= '0;
        end else if (brg_en) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt <= '0;
        end else if (start_ok) begin
            bcnt <= '0;
        end else if (bit_tick) begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // Right shift into the MSB keeps LSB-first bits in natural order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (bit_tick) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

    // A load beats a simultaneous clr_rda; the read that coincides with
    // the load consumed the previous byte, so no overrun is reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (load) begin
            rx_data     <= shreg;
            rda         <= 1'b1;
            framing_err <= ~rxs;
            overrun     <= !clr_rda && (overrun || rda);
        end else if (clr_rda) begin
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule
